// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready handshake, accumulate
// (chain) mode that feeds out_y back as operand B, result flags and a saturating beat counter.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] count
);

    // Handshake: a beat transfers on an edge where valid && ready are both high;
    // the offering side holds its data stable until that edge. Single-stage pipe,
    // so a drain frees the slot for an accept on the same edge.
    logic [WIDTH-1:0] r_y;
    logic             r_valid;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_f;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Chained beats use the current result register as the accumulator.
    assign w_b = in_op[3] ? r_y : in_b;

    always_comb begin
        w_f = '0;
        case (in_op[2:0])
            3'd0: w_f = in_a & w_b;
            3'd1: w_f = ~(in_a & w_b);
            3'd2: w_f = in_a | w_b;
            3'd3: w_f = ~(in_a | w_b);
            3'd4: w_f = in_a ^ w_b;
            3'd5: w_f = ~(in_a ^ w_b);
            3'd6: w_f = ~in_a;
            3'd7: w_f = in_a;
            default: w_f = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_y     <= w_f;
            r_valid <= 1'b1;
            if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
        end else if (r_valid && out_ready) begin
            // out_y is retained so a later chained beat still sees it.
            r_valid <= 1'b0;
        end
    end

    assign out_y     = r_y;
    assign out_valid = r_valid;
    assign count     = r_count;
    assign out_zero  = (r_y == '0);
    assign out_ones  = (r_y == {WIDTH{1'b1}});

endmodule
